// File: rtl/cr_multi_port_reset_seq.sv
// ---------------------------------------------------------------------------
// cr_multi_port_reset_seq
//
// Purpose:
//   Reset sequencer for the DDR3 unit-level top. Produces one active-low
//   aresetn per AXI port from the board-level reset. All ports are held in
//   reset, the block waits for the memory model to finish initialising (or
//   times out), then releases the ports one at a time, STAGGER_CYC apart.
//   Once running, each port can optionally be soft-reset on its own.
//
// Optional feature:
//   CR_RST_SEQ_SW_RST_EN  when defined, builds the per-port soft-reset logic
//                         (one HOLD_CYC down-counter per port). When not
//                         defined, sw_rst_req_i is ignored and released ports
//                         stay high in RUN.
//
// Ports:
//   clk_i            single clock for all logic
//   rst_n_i          asynchronous active-low reset
//   mem_init_done_i  memory init complete (level, clk_i domain)
//   sw_rst_req_i     per-port soft-reset request, 1-cycle pulse
//   port_aresetn_o   per-port active-low reset to AXI port i
//   port_rst_busy_o  1 while port i is held in reset by this block
//   seq_done_o       1 once every port has been released after power-on
//   init_timeout_o   sticky, mem_init_done_i missed the INIT_TO_CYC window
//
// State table:
//   state       | meaning
//   S_HOLD      | all ports in reset, counting HOLD_CYC after synchronised release
//   S_WAIT_INIT | waiting for mem_init_done_i, bounded by INIT_TO_CYC
//   S_RELEASE   | releasing ports in index order, STAGGER_CYC apart
//   S_RUN       | terminal; only soft resets act
// ---------------------------------------------------------------------------
module cr_multi_port_reset_seq #(
    parameter int NUM_PORTS   = 2,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int INIT_TO_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 mem_init_done_i,
    input  logic [NUM_PORTS-1:0] sw_rst_req_i,
    output logic [NUM_PORTS-1:0] port_aresetn_o,
    output logic [NUM_PORTS-1:0] port_rst_busy_o,
    output logic                 seq_done_o,
    output logic                 init_timeout_o
);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_INIT = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HOLD_TC   = CNT_W'(HOLD_CYC);
    // WAIT_INIT counter starts at 0 on entry, so the INIT_TO_CYC-th cycle
    // is the one where the count reads INIT_TO_CYC-1.
    localparam logic [CNT_W-1:0]  INIT_TC   = CNT_W'(INIT_TO_CYC - 1);
    localparam logic [CNT_W-1:0]  STAG_TC   = CNT_W'(STAGGER_CYC);
    localparam logic [PORT_W-1:0] PORT_ONE  = PORT_W'(1);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    logic                 rst_meta_q;
    logic                 rst_sync_q;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [PORT_W-1:0]    port_idx_q;
    logic [NUM_PORTS-1:0] port_aresetn_q;
    logic [NUM_PORTS-1:0] port_rst_busy_q;
    logic                 seq_done_q;
    logic                 init_timeout_q;

`ifdef CR_RST_SEQ_SW_RST_EN
    logic [CNT_W-1:0]     sw_cnt_q [NUM_PORTS];
`else
    logic                 sw_rst_req_unused;
    assign sw_rst_req_unused = ^sw_rst_req_i;
`endif

    // Reset synchroniser: assertion is asynchronous, release takes two edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= S_HOLD;
            cnt_q           <= '0;
            port_idx_q      <= '0;
            port_aresetn_q  <= '0;
            port_rst_busy_q <= '1;
            seq_done_q      <= 1'b0;
            init_timeout_q  <= 1'b0;
`ifdef CR_RST_SEQ_SW_RST_EN
            for (int p = 0; p < NUM_PORTS; p++) begin
                sw_cnt_q[p] <= '0;
            end
`endif
        end else if (rst_sync_q) begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        state_q <= S_WAIT_INIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_WAIT_INIT: begin
                    if (mem_init_done_i || (cnt_q == INIT_TC)) begin
                        if (!mem_init_done_i) begin
                            init_timeout_q <= 1'b1;
                        end
                        // Port 0 goes out on the RELEASE entry edge itself.
                        port_aresetn_q[0]  <= 1'b1;
                        port_rst_busy_q[0] <= 1'b0;
                        cnt_q              <= CNT_ONE;
                        port_idx_q         <= PORT_ONE;
                        if (NUM_PORTS == 1) begin
                            seq_done_q <= 1'b1;
                            state_q    <= S_RUN;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_RELEASE: begin
                    if (cnt_q == STAG_TC) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (PORT_W'(p) == port_idx_q) begin
                                port_aresetn_q[p]  <= 1'b1;
                                port_rst_busy_q[p] <= 1'b0;
                            end
                        end
                        cnt_q      <= CNT_ONE;
                        port_idx_q <= port_idx_q + PORT_ONE;
                        if (port_idx_q == LAST_PORT) begin
                            seq_done_q <= 1'b1;
                            state_q    <= S_RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_RUN: begin
`ifdef CR_RST_SEQ_SW_RST_EN
                    // Each port runs its own down-counter; a fresh request
                    // reloads it, so overlapping requests extend the pulse.
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (sw_rst_req_i[p]) begin
                            sw_cnt_q[p]        <= HOLD_TC;
                            port_aresetn_q[p]  <= 1'b0;
                            port_rst_busy_q[p] <= 1'b1;
                        end else if (sw_cnt_q[p] == CNT_ONE) begin
                            sw_cnt_q[p]        <= '0;
                            port_aresetn_q[p]  <= 1'b1;
                            port_rst_busy_q[p] <= 1'b0;
                        end else if (sw_cnt_q[p] != '0) begin
                            sw_cnt_q[p] <= sw_cnt_q[p] - CNT_ONE;
                        end
                    end
`else
                    state_q <= S_RUN;
`endif
                end

                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    assign port_aresetn_o  = port_aresetn_q;
    assign port_rst_busy_o = port_rst_busy_q;
    assign seq_done_o      = seq_done_q;
    assign init_timeout_o  = init_timeout_q;

endmodule
